pixel_array_ctrl: RTL and testbench
===================================

PIXEL_ARRAY_CTRL -- requirements
Module: pixel_array_ctrl

Interface
REQ-001 Parameter ERASE_CYCLES, default 5: number of cycles ERASE is held high.
REQ-002 Parameter EXPOSE_CYCLES, default 255: number of cycles EXPOSE is held high.
REQ-003 Parameter CNT_W, default 8: width of the conversion counter and the pixel data.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: frame request; sampled only in IDLE.
REQ-007 Ports ERASE, EXPOSE, READ1 and READ2, outputs, 1 each: pixel-array control; READ1 selects pixels 1/2 and READ2 selects pixels 3/4.
REQ-008 Port ramp_en, output, 1: high during CONVERT to enable the external ramp generator.
REQ-009 Port cnt_out, output, CNT_W: conversion count driven onto the four DATA buses.
REQ-010 Port cnt_oe, output, 1: tristate enable for cnt_out onto the DATA buses.
REQ-011 Ports data_in1 to data_in4, inputs, CNT_W each: DATA bus values read back from the pixels.
REQ-012 Port pix_data, output, CNT_W: pixel value on the output stream.
REQ-013 Port pix_idx, output, 2: pixel index on the output stream, 0 to 3.
REQ-014 Port pix_valid, output, 1: stream valid.
REQ-015 Port pix_ready, input, 1: stream ready.
REQ-016 Port frame_done, output, 1: single-cycle pulse at the end of a frame.

Function
REQ-017 The FSM SHALL have the states IDLE, ERASE, EXPOSE, CONVERT, RD1, OUT1, RD2 and OUT2.
REQ-018 IDLE with start=1 SHALL move to ERASE on the next cycle; start SHALL be ignored in every other state.
REQ-019 ERASE SHALL hold ERASE=1 for exactly ERASE_CYCLES cycles and then move to EXPOSE.
REQ-020 EXPOSE SHALL hold EXPOSE=1 for exactly EXPOSE_CYCLES cycles and then move to CONVERT.
REQ-021 CONVERT SHALL last 2^CNT_W cycles.
- ramp_en=1 and cnt_oe=1 throughout.
- cnt_out=0 on the first cycle, incrementing by 1 per cycle up to the all-ones value.
- Then move to RD1 with cnt_oe=0 from that cycle on.
REQ-022 RD1 SHALL last 2 cycles with READ1=1 on both.
- On the second cycle, data_in1 is captured into buffer slot 0 and data_in2 into slot 1.
- Then move to OUT1.
REQ-023 OUT1 SHALL present slot 0 (pix_idx=0) and then slot 1 (pix_idx=1) with pix_valid=1.
- Each transfer completes on a cycle where pix_valid and pix_ready are both 1.
- pix_data and pix_idx SHALL stay stable while pix_valid=1 and pix_ready=0.
- After the second transfer, move to RD2.
REQ-024 RD2 and OUT2 SHALL mirror RD1 and OUT1, using READ2, data_in3/data_in4 and indices 2 and 3.
REQ-025 The last transfer in OUT2 SHALL move the FSM to IDLE and pulse frame_done=1 on that same cycle.
REQ-026 cnt_oe SHALL never be 1 in the same cycle as READ1 or READ2 (no bus contention).
REQ-027 At most one of ERASE, EXPOSE, READ1 and READ2 SHALL be high in any cycle.
REQ-028 Stalling with pix_ready=0 SHALL hold the FSM in OUT1/OUT2 indefinitely with all control outputs low.
REQ-029 The conversion counter SHALL NOT wrap within CONVERT, and no value SHALL be repeated.

Reset
REQ-030 reset=1 SHALL, on the next rising edge, force the state to IDLE.
- All outputs go to 0: ERASE, EXPOSE, READ1, READ2, ramp_en, cnt_oe, cnt_out, pix_valid, pix_data, pix_idx and frame_done.
- Buffers and counters are cleared.
REQ-031 reset asserted mid-frame SHALL abort the frame with no frame_done pulse; reset SHALL take priority over start.

Configuration
REQ-032 Macro PIXEL_GRAY_CODE_EN, when defined: cnt_out SHALL carry the Gray code of the binary count, and each captured value SHALL be converted from Gray to binary before it appears on pix_data.
REQ-033 Without PIXEL_GRAY_CODE_EN: cnt_out SHALL be the plain binary count, and captured values SHALL pass to pix_data unchanged.

Structure
REQ-034 The shared package pixel_pkg SHALL hold the FSM state enum, CNT_W and the bin2gray/gray2bin functions.
REQ-035 One sub-module, pixel_cnt_gen, SHALL hold the conversion counter and its optional Gray encoding; the FSM and readout buffer stay in pixel_array_ctrl.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Start pulse with defaults -> ERASE high 5 cycles, EXPOSE high 255, ramp_en high 256, READ1 high 2, READ2 high 2; cnt_out runs 0..255.
- data_in1..4 = 0x12, 0x34, 0x56, 0x78 and pix_ready=1 -> stream (0,0x12), (1,0x34), (2,0x56), (3,0x78); frame_done pulses with the last beat.
- pix_ready held low 10 cycles in OUT1 -> pix_data=0x12 and pix_idx=0 stable throughout; no READ2 until both OUT1 beats are accepted.
- reset asserted during CONVERT at count 100 -> all outputs 0 on the next edge; no frame_done; a new start runs a full frame.
- PIXEL_GRAY_CODE_EN defined and data_in1=0x0C (Gray) -> pix_data=0x08; cnt_out sequence 0x00, 0x01, 0x03, 0x02, and so on.
- start held high continuously -> back-to-back frames with exactly one IDLE cycle between frame_done and the next ERASE.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel array controller: FSM state encoding,
// default data width and the Gray-code conversion functions.
package pixel_pkg;

    localparam int CNT_W  = 8;
    // The Gray helpers work on a fixed wide word so that any CNT_W up to this width can use them.
    localparam int GRAY_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_RD1,
        ST_OUT1,
        ST_RD2,
        ST_OUT2
    } state_e;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_array_ctrl_if.sv
// Pixel output stream: one beat per pixel, accepted when pix_valid and pix_ready are both high.
interface pixel_array_ctrl_if #(parameter int W = 8);
    logic [W-1:0] pix_data;
    logic [1:0]   pix_idx;
    logic         pix_valid;
    logic         pix_ready;

    modport master (output pix_data, pix_idx, pix_valid, input pix_ready);
    modport slave  (input pix_data, pix_idx, pix_valid, output pix_ready);
endinterface

// File: rtl/pixel_cnt_gen.sv
// Conversion counter driven onto the DATA buses; Gray-coded when PIXEL_GRAY_CODE_EN is defined.
module pixel_cnt_gen
    import pixel_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt_out,
    output logic         last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Held at zero outside the conversion window so each conversion starts from 0.
    always_comb begin
        count_d = en ? count_q + W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = en && (count_q == '1);

`ifdef PIXEL_GRAY_CODE_EN
    assign cnt_out = W'(bin2gray(GRAY_W'(count_q)));
`else
    assign cnt_out = count_q;
`endif

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a 4-pixel array: erase, expose, ramp conversion, then two-pair readout
// onto a valid/ready stream. PIXEL_GRAY_CODE_EN selects Gray-coded conversion counts.
module pixel_array_ctrl #(
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    parameter int CNT_W         = pixel_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                ERASE,
    output logic                EXPOSE,
    output logic                READ1,
    output logic                READ2,
    output logic                ramp_en,
    output logic [CNT_W-1:0]    cnt_out,
    output logic                cnt_oe,
    input  logic [CNT_W-1:0]    data_in1,
    input  logic [CNT_W-1:0]    data_in2,
    input  logic [CNT_W-1:0]    data_in3,
    input  logic [CNT_W-1:0]    data_in4,
    pixel_array_ctrl_if.master  pix,
    output logic                frame_done
);
    import pixel_pkg::*;

    state_e             state_q, state_d;
    logic [31:0]        cyc_q, cyc_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   slot_q [4];
    logic [CNT_W-1:0]   slot_d [4];
    logic               cnt_en;
    logic               cnt_last;
    logic [CNT_W-1:0]   cur_slot;

    pixel_cnt_gen #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .en      (cnt_en),
        .cnt_out (cnt_out),
        .last    (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        idx_d      = idx_q;
        cnt_en     = 1'b0;
        frame_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ERASE;
                    cyc_d   = '0;
                end
            end
            ST_ERASE: begin
                if (cyc_q == 32'(ERASE_CYCLES - 1)) begin
                    state_d = ST_EXPOSE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            ST_EXPOSE: begin
                if (cyc_q == 32'(EXPOSE_CYCLES - 1)) begin
                    state_d = ST_CONVERT;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            ST_CONVERT: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d = ST_RD1;
                    cyc_d   = '0;
                end
            end
            ST_RD1: begin
                // Pixels have settled onto the buses by the second READ1 cycle.
                if (cyc_q == 32'd1) begin
                    slot_d[0] = data_in1;
                    slot_d[1] = data_in2;
                    state_d   = ST_OUT1;
                    idx_d     = 2'd0;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            ST_OUT1: begin
                if (pix.pix_ready) begin
                    if (idx_q == 2'd1) begin
                        state_d = ST_RD2;
                        cyc_d   = '0;
                    end
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_RD2: begin
                if (cyc_q == 32'd1) begin
                    slot_d[2] = data_in3;
                    slot_d[3] = data_in4;
                    state_d   = ST_OUT2;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            ST_OUT2: begin
                if (pix.pix_ready) begin
                    if (idx_q == 2'd3) begin
                        state_d    = ST_IDLE;
                        frame_done = 1'b1;
                    end
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (reset) begin
                slot_q[gi] <= '0;
            end else begin
                slot_q[gi] <= slot_d[gi];
            end
        end
    end

    // Every control strobe decodes from a single state, so they are mutually exclusive by construction.
    assign ERASE   = (state_q == ST_ERASE);
    assign EXPOSE  = (state_q == ST_EXPOSE);
    assign READ1   = (state_q == ST_RD1);
    assign READ2   = (state_q == ST_RD2);
    assign ramp_en = (state_q == ST_CONVERT);
    assign cnt_oe  = (state_q == ST_CONVERT);

`ifdef PIXEL_GRAY_CODE_EN
    assign cur_slot = CNT_W'(gray2bin(GRAY_W'(slot_q[idx_q])));
`else
    assign cur_slot = slot_q[idx_q];
`endif

    assign pix.pix_valid = (state_q == ST_OUT1) || (state_q == ST_OUT2);
    assign pix.pix_data  = pix.pix_valid ? cur_slot : '0;
    assign pix.pix_idx   = pix.pix_valid ? idx_q : 2'd0;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Scoreboard bench for pixel_array_ctrl: frames with random pixel data and ready stalls,
// mid-frame reset, back-to-back frames; reference model follows PIXEL_GRAY_CODE_EN.
module tb_pixel_array_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         erase_o, expose_o, read1_o, read2_o, ramp_en, cnt_oe, frame_done;
    logic [W-1:0] cnt_out;
    logic [W-1:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    int           ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
    logic         b2b = 1'b0;

    int checks = 0;
    int errors = 0;

    pixel_array_ctrl_if #(.W(W)) pix_if ();

    pixel_array_ctrl #(.ERASE_CYCLES(5), .EXPOSE_CYCLES(255), .CNT_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ERASE      (erase_o),
        .EXPOSE     (expose_o),
        .READ1      (read1_o),
        .READ2      (read2_o),
        .ramp_en    (ramp_en),
        .cnt_out    (cnt_out),
        .cnt_oe     (cnt_oe),
        .data_in1   (d1),
        .data_in2   (d2),
        .data_in3   (d3),
        .data_in4   (d4),
        .pix        (pix_if),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired act=running req=finished");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_if.pix_ready = 1'b1;
            1:       pix_if.pix_ready = 1'($urandom_range(0, 1));
            default: pix_if.pix_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=0x%0h req=0x%0h", nm, act, req);
        end
    endtask

    // Reference model: a pixel's stream value is its bus value, decoded from Gray when enabled.
    function automatic logic [W-1:0] model_pix(input logic [W-1:0] raw);
`ifdef PIXEL_GRAY_CODE_EN
        logic [W-1:0] b = '0;
        for (int s = 0; s < W; s++) b = b ^ (raw >> s);
        return b;
`else
        return raw;
`endif
    endfunction

    function automatic logic [W-1:0] model_cnt(input int n);
        logic [W-1:0] v = W'(n);
`ifdef PIXEL_GRAY_CODE_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    typedef struct {
        logic [1:0]   idx;
        logic [W-1:0] data;
    } beat_t;
    beat_t exp_q[$];

    task automatic push_frame();
        logic [W-1:0] raw [4];
        raw[0] = d1; raw[1] = d2; raw[2] = d3; raw[3] = d4;
        for (int i = 0; i < 4; i++) exp_q.push_back('{idx: 2'(i), data: model_pix(raw[i])});
    endtask

    // Monitor: pulse widths, counter sequence, exclusivity, stream beats, frame_done, b2b gap.
    int           run [5];
    int           exp_len [5] = '{5, 255, 256, 2, 2};
    string        run_nm [5] = '{"erase_len", "expose_len", "ramp_len", "read1_len", "read2_len"};
    logic         stall_q = 1'b0;
    logic [W-1:0] stall_data;
    logic [1:0]   stall_idx;
    logic         gap_armed = 1'b0;
    int           gap = 0;

    always @(negedge clk) begin
        logic [4:0] sig;
        beat_t      e;
        sig = {read2_o, read1_o, ramp_en, expose_o, erase_o};
        if (reset) begin
            for (int i = 0; i < 5; i++) run[i] = 0;
            stall_q   = 1'b0;
            gap_armed = 1'b0;
        end else begin
            chk("ctrl_onehot", 32'($countones({erase_o, expose_o, read1_o, read2_o}) <= 1), 1);
            chk("bus_contention", cnt_oe & (read1_o | read2_o), 0);
            chk("cnt_oe_window", cnt_oe, ramp_en);
            if (ramp_en) chk("cnt_out", cnt_out, model_cnt(run[2]));
            for (int i = 0; i < 5; i++) begin
                if (sig[i]) run[i]++;
                else if (run[i] > 0) begin
                    chk(run_nm[i], run[i], exp_len[i]);
                    run[i] = 0;
                end
            end
            if (stall_q) begin
                chk("stall_valid", pix_if.pix_valid, 1);
                chk("stall_data", pix_if.pix_data, stall_data);
                chk("stall_idx", pix_if.pix_idx, stall_idx);
            end
            stall_q    = pix_if.pix_valid && !pix_if.pix_ready;
            stall_data = pix_if.pix_data;
            stall_idx  = pix_if.pix_idx;
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat act=idx%0d req=none", pix_if.pix_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_idx", pix_if.pix_idx, e.idx);
                    chk("beat_data", pix_if.pix_data, e.data);
                    chk("frame_done_last", frame_done, e.idx == 2'd3);
                    $display("beat idx=%0d data=0x%02h", pix_if.pix_idx, pix_if.pix_data);
                end
            end else begin
                chk("frame_done_spurious", frame_done, 0);
            end
            if (frame_done) begin
                gap       = 0;
                gap_armed = 1'b1;
            end else if (gap_armed) begin
                gap++;
                if (erase_o) begin
                    if (b2b) chk("b2b_gap", gap, 2);
                    gap_armed = 1'b0;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_erase"}, erase_o, 0);
        chk({tag, "_expose"}, expose_o, 0);
        chk({tag, "_read1"}, read1_o, 0);
        chk({tag, "_read2"}, read2_o, 0);
        chk({tag, "_ramp"}, ramp_en, 0);
        chk({tag, "_cnt_oe"}, cnt_oe, 0);
        chk({tag, "_cnt_out"}, cnt_out, 0);
        chk({tag, "_valid"}, pix_if.pix_valid, 0);
        chk({tag, "_data"}, pix_if.pix_data, 0);
        chk({tag, "_idx"}, pix_if.pix_idx, 0);
        chk({tag, "_done"}, frame_done, 0);
    endtask

    task automatic issue_start();
        @(negedge clk);
        start = 1'b1;
        push_frame();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 5000);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout act=0 req=1");
        end
    endtask

    task automatic run_frame();
        issue_start();
        wait_done();
        $display("frame done data=%02h %02h %02h %02h", d1, d2, d3, d4);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        d1 = 8'h12; d2 = 8'h34; d3 = 8'h56; d4 = 8'h78;
        run_frame();

        ready_mode = 2;
        issue_start();
        n = 0;
        do begin @(negedge clk); n++; end while (!pix_if.pix_valid && n < 2000);
        chk("stall_reached", pix_if.pix_valid, 1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_hold_data", pix_if.pix_data, model_pix(8'h12));
            chk("stall_hold_idx", pix_if.pix_idx, 0);
            chk("stall_no_read2", read2_o, 0);
        end
        ready_mode = 0;
        wait_done();
        $display("stall frame done");

        ready_mode = 1;
        repeat (2) begin
            d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom); d4 = W'($urandom);
            run_frame();
        end
        ready_mode = 0;

        issue_start();
        n = 0;
        do begin @(negedge clk); n++; end while (!(ramp_en && cnt_out == model_cnt(100)) && n < 2000);
        chk("abort_point", ramp_en, 1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_zero("abort");
        reset = 1'b0;
        $display("frame aborted at count 100");
        run_frame();

        b2b = 1'b1;
        @(negedge clk);
        start = 1'b1;
        repeat (3) push_frame();
        repeat (3) wait_done();
        start = 1'b0;
        b2b = 1'b0;
        $display("back-to-back frames done");

        d1 = 8'h0C; d2 = W'($urandom); d3 = W'($urandom); d4 = W'($urandom);
        run_frame();

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
